// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: immediate-format codes, encoder FIFO entry and
// state types, and the immediate sign-extension helper (inverse of packing).
package riscv_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_U = 3'b001;
  localparam logic [2:0] IMM_J = 3'b010;
  localparam logic [2:0] IMM_S = 3'b011;
  localparam logic [2:0] IMM_B = 3'b100;

  typedef struct packed {
    logic            err;
    logic [ILEN-1:0] inst;
  } immenc_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } immenc_state_t;

  // Sign-extend the immediate carried by an instruction of the given format.
  function automatic logic [XLEN-1:0] imm_extend(input logic [2:0] src,
                                                 input logic [ILEN-1:0] i);
    logic [XLEN-1:0] r;
    r = '0;
    case (src)
      IMM_I:   r = {{52{i[31]}}, i[31:20]};
      IMM_S:   r = {{52{i[31]}}, i[31:25], i[11:7]};
      IMM_U:   r = {{32{i[31]}}, i[31:12], 12'b0};
      IMM_J:   r = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      IMM_B:   r = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/riscv_immenc_pack.sv
// Combinational immediate packer and legality checker.
// Ports: src (format code), simm (sign-extended immediate), inst (base
// instruction), enc (encoded instruction, = inst when err), err (immediate not
// representable or format code invalid).
module riscv_immenc_pack
  import riscv_pkg::*;
(
  input  logic [2:0]      src,
  input  logic [XLEN-1:0] simm,
  input  logic [ILEN-1:0] inst,
  output logic [ILEN-1:0] enc,
  output logic            err
);

  logic [ILEN-1:0] packed_inst;
  logic            legal;

  // Upper bits must be a pure sign extension of the field's top bit.
  logic sx11, sx12, sx20, sx31;
  assign sx11 = (&simm[63:11]) | ~(|simm[63:11]);
  assign sx12 = (&simm[63:12]) | ~(|simm[63:12]);
  assign sx20 = (&simm[63:20]) | ~(|simm[63:20]);
  assign sx31 = (&simm[63:31]) | ~(|simm[63:31]);

  always_comb begin
    packed_inst = inst;
    legal       = 1'b0;
    case (src)
      IMM_I: begin
        packed_inst[31:20] = simm[11:0];
        legal              = sx11;
      end
      IMM_U: begin
        packed_inst[31:12] = simm[31:12];
        legal              = sx31 && (simm[11:0] == 12'd0);
      end
      IMM_J: begin
        packed_inst[31]    = simm[20];
        packed_inst[30:21] = simm[10:1];
        packed_inst[20]    = simm[11];
        packed_inst[19:12] = simm[19:12];
        legal              = sx20 && !simm[0];
      end
      IMM_S: begin
        packed_inst[31:25] = simm[11:5];
        packed_inst[11:7]  = simm[4:0];
        legal              = sx11;
      end
      IMM_B: begin
        packed_inst[31]    = simm[12];
        packed_inst[30:25] = simm[10:5];
        packed_inst[11:8]  = simm[4:1];
        packed_inst[7]     = simm[11];
        legal              = sx12 && !simm[0];
      end
      default: legal = 1'b0;
    endcase
  end

  assign err = !legal;
  assign enc = legal ? packed_inst : inst;

endmodule

// File: rtl/riscv_imm_encoder.sv
// RISC-V immediate encoder with a 2-entry in-order result FIFO and a
// saturating error counter.
// Ports: clk/rst (async active-high), request valid/ready/immsrc/simm/inst,
// result valid/ready/inst/err, errcnt (accepted errored requests).
module riscv_imm_encoder
  import riscv_pkg::*;
#(
  parameter int unsigned ERRCNT_W = 8
) (
  input  logic                i_riscv_immenc_clk,
  input  logic                i_riscv_immenc_rst,
  input  logic                i_riscv_immenc_valid,
  output logic                o_riscv_immenc_ready,
  input  logic [2:0]          i_riscv_immenc_immsrc,
  input  logic [XLEN-1:0]     i_riscv_immenc_simm,
  input  logic [ILEN-1:0]     i_riscv_immenc_inst,
  output logic                o_riscv_immenc_valid,
  input  logic                i_riscv_immenc_ready,
  output logic [ILEN-1:0]     o_riscv_immenc_inst,
  output logic                o_riscv_immenc_err,
  output logic [ERRCNT_W-1:0] o_riscv_immenc_errcnt
);

  immenc_state_t         state_q, state_d;
  immenc_entry_t         head_q, head_d, tail_q, tail_d, new_entry;
  logic                  valid_q, ready_q;
  logic [ERRCNT_W-1:0]   errcnt_q;
  logic                  push, pop;

  riscv_immenc_pack u_pack (
    .src  (i_riscv_immenc_immsrc),
    .simm (i_riscv_immenc_simm),
    .inst (i_riscv_immenc_inst),
    .enc  (new_entry.inst),
    .err  (new_entry.err)
  );

  assign push = i_riscv_immenc_valid && ready_q;
  assign pop  = valid_q && i_riscv_immenc_ready;

  // Next state and FIFO contents; head is always the presented result.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          head_d  = new_entry;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          head_d = new_entry;
        end else if (push) begin
          tail_d  = new_entry;
          state_d = ST_FULL;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // ready is low in FULL, so no push can arrive here.
        if (pop) begin
          head_d  = tail_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Registers; valid/ready are flopped from the next state so neither has a
  // combinational path from the downstream ready.
  always_ff @(posedge i_riscv_immenc_clk or posedge i_riscv_immenc_rst) begin
    if (i_riscv_immenc_rst) begin
      state_q  <= ST_EMPTY;
      head_q   <= '0;
      tail_q   <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= (state_d != ST_EMPTY);
      ready_q <= (state_d != ST_FULL);
      if (push && new_entry.err && (errcnt_q != {ERRCNT_W{1'b1}})) begin
        errcnt_q <= errcnt_q + ERRCNT_W'(1);
      end
    end
  end

  assign o_riscv_immenc_ready  = ready_q;
  assign o_riscv_immenc_valid  = valid_q;
  assign o_riscv_immenc_inst   = head_q.inst;
  assign o_riscv_immenc_err    = head_q.err;
  assign o_riscv_immenc_errcnt = errcnt_q;

endmodule

// File: tb/tb_riscv_imm_encoder.sv
// Directed and random round-trip bench for riscv_imm_encoder.
module tb_riscv_imm_encoder;

  logic        clk, rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [2:0]  immsrc;
  logic [63:0] simm;
  logic [31:0] inst, out_inst;
  logic [7:0]  errcnt;

  int n_checks = 0;
  int n_pass   = 0;

  riscv_imm_encoder #(.ERRCNT_W(8)) dut (
    .i_riscv_immenc_clk    (clk),
    .i_riscv_immenc_rst    (rst),
    .i_riscv_immenc_valid  (in_valid),
    .o_riscv_immenc_ready  (in_ready),
    .i_riscv_immenc_immsrc (immsrc),
    .i_riscv_immenc_simm   (simm),
    .i_riscv_immenc_inst   (inst),
    .o_riscv_immenc_valid  (out_valid),
    .i_riscv_immenc_ready  (out_ready),
    .o_riscv_immenc_inst   (out_inst),
    .o_riscv_immenc_err    (out_err),
    .o_riscv_immenc_errcnt (errcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Independent reference decoder of the immediate held in an instruction.
  function automatic logic [63:0] ref_ext(input logic [2:0] s, input logic [31:0] i);
    case (s)
      3'd0:    return {{52{i[31]}}, i[31:20]};
      3'd3:    return {{52{i[31]}}, i[31:25], i[11:7]};
      3'd1:    return {{32{i[31]}}, i[31:12], 12'b0};
      3'd2:    return {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      3'd4:    return {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      default: return 64'd0;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Present one request, wait (bounded) for ready, return just after accept.
  task automatic send(input string tag, input logic [2:0] s, input logic [63:0] v,
                      input logic [31:0] b);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    immsrc   = s;
    simm     = v;
    inst     = b;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check({tag, "_rdy_timeout"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_req(input string tag, input logic [2:0] s, input logic [63:0] v,
                        input logic [31:0] b, input logic [31:0] exp_inst,
                        input logic exp_err);
    send(tag, s, v, b);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_inst"}, 64'(out_inst), 64'(exp_inst));
    check({tag, "_err"}, 64'(out_err), 64'(exp_err));
  endtask

  initial begin
    logic [2:0]  rs;
    logic [63:0] rv;
    logic [31:0] ri;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    immsrc = '0; simm = '0; inst = '0;

    // Reset values, then ready rises on the first edge after release.
    #12;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_inst", 64'(out_inst), 64'd0);
    check("rst_err", 64'(out_err), 64'd0);
    check("rst_errcnt", 64'(errcnt), 64'd0);
    @(negedge clk); rst = 1'b0;
    #1 check("rel_ready_pre_edge", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    check("rel_ready_post_edge", 64'(in_ready), 64'd1);

    // Directed encodings.
    do_req("i_neg1", 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0000_0093, 32'hFFF0_0093, 1'b0);
    do_req("u_ok", 3'd1, 64'h1234_5000, 32'h0000_02B7, 32'h1234_52B7, 1'b0);
    do_req("u_low", 3'd1, 64'h1234_5001, 32'h0000_02B7, 32'h0000_02B7, 1'b1);
    do_req("s_neg4", 3'd3, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_2023, 32'hFE00_2E23, 1'b0);
    do_req("j_800", 3'd2, 64'h800, 32'h0000_006F, 32'h0010_006F, 1'b0);
    do_req("bad_src", 3'd7, 64'h0, 32'h1234_5678, 32'h1234_5678, 1'b1);
    do_req("i_over", 3'd0, 64'h800, 32'h0000_0013, 32'h0000_0013, 1'b1);

    do_reset();
    do_req("b_800", 3'd4, 64'h800, 32'h0000_0063, 32'h0000_00E3, 1'b0);
    do_req("b_odd", 3'd4, 64'h3, 32'h0000_0063, 32'h0000_0063, 1'b1);
    do_req("j_over", 3'd2, 64'h10_0000, 32'h0000_006F, 32'h0000_006F, 1'b1);
    @(negedge clk);
    check("errcnt_two", 64'(errcnt), 64'd2);

    // Backpressure: three requests with downstream stalled.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; immsrc = 3'd0; inst = 32'h0000_0013; simm = 64'd1;
    @(posedge clk); #1;
    check("bp_a_valid", 64'(out_valid), 64'd1);
    check("bp_a_ready", 64'(in_ready), 64'd1);
    @(negedge clk); simm = 64'd2;
    @(posedge clk); #1;
    check("bp_full_ready", 64'(in_ready), 64'd0);
    check("bp_head_a", 64'(out_inst), 64'h0010_0013);
    @(negedge clk); simm = 64'd3;
    @(posedge clk); #1;
    check("bp_stable_inst", 64'(out_inst), 64'h0010_0013);
    check("bp_stable_valid", 64'(out_valid), 64'd1);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_head_b", 64'(out_inst), 64'h0020_0013);
    check("bp_ready_back", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_head_c", 64'(out_inst), 64'h0030_0013);
    check("bp_c_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    check("bp_drained", 64'(out_valid), 64'd0);

    // Reset while FULL takes effect without a clock edge.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; immsrc = 3'd7; inst = 32'h0;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    check("full_ready", 64'(in_ready), 64'd0);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_errcnt", 64'(errcnt), 64'd0);
    check("arst_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    @(negedge clk); rst = 1'b0;

    // Errored stream to saturate the counter.
    @(negedge clk);
    in_valid = 1'b1; immsrc = 3'd6; inst = 32'hCAFE_0013; simm = 64'd0;
    repeat (300) @(posedge clk);
    #1 in_valid = 1'b0;
    check("sat_inst", 64'(out_inst), 64'hCAFE_0013);
    check("sat_errcnt", 64'(errcnt), 64'd255);
    @(posedge clk); #1;
    check("sat_hold", 64'(errcnt), 64'd255);

    // Random legal round-trip.
    for (int k = 0; k < 10000; k++) begin
      rs = 3'($urandom_range(0, 4));
      ri = $urandom;
      case (rs)
        3'd0, 3'd3: begin rv = 64'($urandom_range(0, 4095)); rv = {{52{rv[11]}}, rv[11:0]}; end
        3'd1:       begin rv = 64'($urandom); rv = {{32{rv[31]}}, rv[31:12], 12'b0}; end
        3'd2:       begin rv = 64'($urandom); rv = {{43{rv[20]}}, rv[20:1], 1'b0}; end
        default:    begin rv = 64'($urandom); rv = {{51{rv[12]}}, rv[12:1], 1'b0}; end
      endcase
      send("rt", rs, rv, ri);
      check("rt_err", 64'(out_err), 64'd0);
      check("rt_simm", ref_ext(rs, out_inst), rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/riscv_imm_encoder.md
RISCV_IMM_ENCODER -- requirements
Module: riscv_imm_encoder

Interface
REQ-001 The block SHALL have parameter ERRCNT_W, default 8, giving the width of the error counter.
REQ-002 The block SHALL have port i_riscv_immenc_clk, input, 1 bit: the single clock; all flops are rising-edge.
REQ-003 The block SHALL have port i_riscv_immenc_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port i_riscv_immenc_valid, input, 1 bit: request valid.
REQ-005 The block SHALL have port o_riscv_immenc_ready, output, 1 bit: request accepted when high together with valid.
REQ-006 The block SHALL have port i_riscv_immenc_immsrc, input, 3 bits: 000 I, 001 U, 010 J, 011 S, 100 B; all other codes are invalid.
REQ-007 The block SHALL have port i_riscv_immenc_simm, input, 64 bits: sign-extended immediate to encode.
REQ-008 The block SHALL have port i_riscv_immenc_inst, input, 32 bits: base instruction supplying all non-immediate fields.
REQ-009 The block SHALL have port o_riscv_immenc_valid, output, 1 bit: result valid.
REQ-010 The block SHALL have port i_riscv_immenc_ready, input, 1 bit: downstream accepts the result.
REQ-011 The block SHALL have port o_riscv_immenc_inst, output, 32 bits: encoded instruction.
REQ-012 The block SHALL have port o_riscv_immenc_err, output, 1 bit: immediate not representable in the requested format.
REQ-013 The block SHALL have port o_riscv_immenc_errcnt, output, ERRCNT_W bits: saturating count of accepted errored requests.

Function
REQ-014 Packing SHALL be as follows; unlisted instruction bits are copied from i_inst.
- I: inst[31:20]=simm[11:0].
- U: inst[31:12]=simm[31:12].
- J: inst[31]=simm[20], [30:21]=simm[10:1], [20]=simm[11], [19:12]=simm[19:12].
- S: inst[31:25]=simm[11:5], [11:7]=simm[4:0].
- B: inst[31]=simm[12], [30:25]=simm[10:5], [11:8]=simm[4:1], [7]=simm[11].
REQ-015 An immediate SHALL be legal only under these conditions; otherwise err=1.
- I/S: simm[63:11] all equal.
- U: simm[63:31] all equal and simm[11:0]=0.
- J: simm[63:20] all equal and simm[0]=0.
- B: simm[63:12] all equal and simm[0]=0.
REQ-016 When err=1 (including an invalid immsrc), o_inst SHALL equal i_inst unmodified.
REQ-017 For every legal request, sign-extending o_inst with the same immsrc SHALL reproduce simm exactly (round-trip property).
REQ-018 Results SHALL be buffered in a 2-entry in-order FIFO with states EMPTY, ONE, FULL.
REQ-019 A request SHALL be accepted on a rising edge where valid and ready are both high; its result SHALL be presented the next cycle (latency 1).
REQ-020 o_ready SHALL be a registered signal, high in EMPTY and ONE and low in FULL, with no combinational path from i_riscv_immenc_ready.
REQ-021 State transitions SHALL follow the push/pop rules below.
- Push without pop: EMPTY->ONE, ONE->FULL.
- Pop without push: FULL->ONE, ONE->EMPTY.
- Simultaneous push and pop in ONE: state stays ONE, with the new entry behind the popped one.
REQ-022 Output data, err, and valid SHALL remain stable while o_valid=1 and i_ready=0.
REQ-023 errcnt SHALL increment by 1 on each accepted request with err=1 and SHALL saturate at all-ones.

Reset
REQ-024 Asserting i_riscv_immenc_rst at any time, including mid-transfer, SHALL asynchronously flush the FIFO to EMPTY.
REQ-025 While in reset, outputs SHALL be: o_valid=0, o_ready=0, o_inst=0, o_err=0, errcnt=0.
REQ-026 o_ready SHALL go to 1 on the first clock edge after reset deasserts.

Structure
REQ-027 The immsrc encodings (IMM_I, IMM_U, IMM_J, IMM_S, IMM_B) SHALL be defined as constants in the shared package riscv_pkg, alongside the existing extend usage.
REQ-028 Packing and legality checking SHALL be one combinational sub-module, riscv_immenc_pack; the FIFO and counter SHALL reside in the top module.

Verification
REQ-029 I-type: inst=0x00000093, simm=0xFFFFFFFFFFFFFFFF -> o_inst=0xFFF00093, err=0.
REQ-030 U-type: inst=0x000002B7, simm=0x12345000 -> o_inst=0x123452B7, err=0; simm=0x12345001 -> err=1, o_inst=0x000002B7.
REQ-031 B-type: inst=0x00000063, simm=0x800 -> o_inst=0x000000E3; simm=0x3 -> err=1; J-type simm=0x100000 -> err=1; errcnt=2 afterwards.
REQ-032 Backpressure: hold i_ready=0 and push 3 requests.
- o_ready drops after the 2nd accept.
- Release i_ready: results emerge in order with no loss or duplication.
REQ-033 Reset asserted in FULL state -> o_valid=0 and errcnt=0 immediately, without waiting for a clock edge.
REQ-034 Random round-trip: 10k legal simm/immsrc pairs -> extend(o_inst) equals simm for every result.
